adc_frame_deframer: RTL and testbench
=====================================

Name: adc_frame_deframer

Overview:
- Receive-side counterpart of the ADC capture framer. Consumes the 64-bit AXI-Stream ADC frame: header beat {glbl_counter, adc_counter}, payload beats {data_upper, data_lower}, and a trailer beat {glbl_counter, adc_counter} marked by tlast.
- Strips header and trailer and forwards payload-only frames with tlast on the last payload beat.
- Latches header and trailer counters, checks frame length against the counter delta, and pulses a per-frame report.
- Sits in the aclk domain downstream of the ADC AXI-Stream wrapper, ahead of the host and Ethernet path.

Parameters:
- DATA_WIDTH, 64, stream width. Upper half is glbl_counter and lower half is adc_counter on header and trailer beats.
- MAX_PAYLOAD, 4096, maximum payload beats forwarded per frame.
- CNT_ADJ, 1, subtracted from (trl_adc - hdr_adc) to give the expected payload beat count.

Ports:
- aclk  in  1  single clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  64  input frame data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  marks the trailer beat.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  64  payload data.
- m_axis_tvalid  out  1  payload valid.
- m_axis_tlast  out  1  last payload beat of the frame.
- m_axis_tready  in  1  downstream ready.
- report_valid  out  1  one-cycle per-frame pulse.
- hdr_glbl, hdr_adc, trl_glbl, trl_adc  out  32 each  latched counters.
- payload_beats  out  32  payload beats forwarded this frame.
- len_err, short_err, oversize_err  out  1 each  frame status, valid with report_valid.
- frame_count  out  32  frames reported since reset, wraps.

Behaviour:
- Reset (async, aresetn=0): state=S_HDR, hold and out stages empty. All outputs 0, except s_axis_tready=1.
- Datapath is two registered stages:
  - hold: the last payload beat, whose tlast status is not yet known.
  - out: drives m_axis_*.
  - out is replaced only when empty or when m_axis_tready=1 in the same cycle.
- Accepted beat: s_axis_tvalid & s_axis_tready.
- s_axis_tready:
  - 1 in S_HDR, S_FIRST and S_DROP.
  - In S_PAY: !out_valid | m_axis_tready.
- S_HDR, on an accepted beat:
  - tlast=1: short_err=1, latch hdr and trl from this beat, payload_beats=0, report, stay in S_HDR.
  - Else: latch hdr_glbl=tdata[63:32], hdr_adc=tdata[31:0], clear the beat counter, go to S_FIRST.
- S_FIRST, on an accepted beat:
  - tlast=1: legal empty frame. Latch trl, payload_beats=0, report, go to S_HDR. Nothing is emitted on m_axis.
  - Else: load hold, count=1, go to S_PAY.
- S_PAY (hold full), on an accepted beat:
  - tlast=1: move hold to out with m_axis_tlast=1, latch trl from the beat, report, go to S_HDR. The trailer is never forwarded.
  - tlast=0 and count<MAX_PAYLOAD: move hold to out with tlast=0, load the beat into hold, count+1.
  - tlast=0 and count==MAX_PAYLOAD: move hold to out with tlast=1, discard the beat, oversize_err pending, go to S_DROP.
- S_DROP: discard every accepted beat. The tlast beat latches trl, reports, and returns to S_HDR.
- Report (cycle after the terminating beat is accepted):
  - report_valid=1 for exactly one cycle.
  - frame_count+1, wrapping 2^32-1 to 0.
  - hdr/trl/payload_beats/error outputs hold until the next report.
  - len_err = (payload_beats != (trl_adc - hdr_adc - CNT_ADJ) mod 2^32). len_err is forced 0 when short_err or oversize_err is set.
- The header and trailer counter fields are not interpreted beyond the length check. Wrap in the subtraction is modular.
- Latency: a payload beat appears on m_axis one accepted input beat later, plus one cycle of registration.
- Throughput: 1 beat per cycle when m_axis_tready=1.
- Output handshake: m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous events: when the out stage drains and refills in the same cycle, m_axis_tvalid stays 1.
- A header accepted in S_HDR while out still holds the previous tlast beat is legal and does not stall.
- Reset mid-frame: all state is discarded and the partial frame is not reported. The first beat after reset is treated as a header.

Test Plan:
- Nominal frame: hdr {0x100, 0x10}, payload P1..P4, trl {0x108, 0x15} with tlast, tready=1. Expect:
  - P1..P4 on m_axis in order, tlast only on P4.
  - report_valid once with payload_beats=4, len_err=0, frame_count=1.
  - trl_adc=0x15.
- Backpressure: same frame with m_axis_tready toggling 1,0,0,1… Expect:
  - No beat lost or duplicated, data stable while stalled.
  - s_axis_tready low only in S_PAY while out is full and not ready.
- Length error: hdr_adc=0x10, 4 payload beats, trl_adc=0x18 → report with len_err=1, payload_beats=4.
- Degenerate frames:
  - Single tlast beat → short_err=1, no m_axis output.
  - Header followed by a tlast trailer → payload_beats=0, short_err=0, no m_axis output.
- Oversize, with MAX_PAYLOAD=4: hdr, 7 payload beats, trl → 4 beats forwarded with tlast on the 4th, remainder dropped, oversize_err=1, len_err=0.
- Reset and wrap:
  - Assert aresetn=0 after 2 payload beats → outputs cleared immediately. A new full frame afterward reports frame_count=1.
  - hdr_adc=0xFFFFFFFE, 2 payload beats, trl_adc=0x00000001 → len_err=0.

Source files
------------

// File: rtl/adc_frame_deframer.sv
// Strips header/trailer beats from the ADC AXI-Stream frame, forwards payload only,
// and publishes latched counters plus length/short/oversize status once per frame.
module adc_frame_deframer #(
  parameter int DATA_WIDTH  = 64,
  parameter int MAX_PAYLOAD = 4096,
  parameter int CNT_ADJ     = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  report_valid,
  output logic [31:0]           hdr_glbl,
  output logic [31:0]           hdr_adc,
  output logic [31:0]           trl_glbl,
  output logic [31:0]           trl_adc,
  output logic [31:0]           payload_beats,
  output logic                  len_err,
  output logic                  short_err,
  output logic                  oversize_err,
  output logic [31:0]           frame_count
);

  typedef enum logic [1:0] {S_HDR, S_FIRST, S_PAY, S_DROP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] holdData_q, holdData_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic                  outValid_q, outValid_d;
  logic                  outLast_q, outLast_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           pendGlbl_q, pendGlbl_d;
  logic [31:0]           pendAdc_q, pendAdc_d;
  logic [31:0]           hdrGlbl_q, hdrGlbl_d;
  logic [31:0]           hdrAdc_q, hdrAdc_d;
  logic [31:0]           trlGlbl_q, trlGlbl_d;
  logic [31:0]           trlAdc_q, trlAdc_d;
  logic [31:0]           payloadBeats_q, payloadBeats_d;
  logic                  lenErr_q, lenErr_d;
  logic                  shortErr_q, shortErr_d;
  logic                  oversizeErr_q, oversizeErr_d;
  logic                  reportValid_q, reportValid_d;
  logic [31:0]           frameCount_q, frameCount_d;

  logic                  accept;
  logic                  doReport;
  logic [31:0]           repHdrGlbl, repHdrAdc, repBeats, expBeats;
  logic                  repShort, repOver;
  logic [31:0]           beatUpper, beatLower;

  assign beatUpper = s_axis_tdata[DATA_WIDTH-1 -: 32];
  assign beatLower = s_axis_tdata[31:0];

  // Only payload forwarding can stall the input; header/trailer/drop beats are always taken.
  assign s_axis_tready = (state_q == S_PAY) ? (!outValid_q || m_axis_tready) : 1'b1;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d        = state_q;
    holdData_d     = holdData_q;
    outData_d      = outData_q;
    outValid_d     = outValid_q && !m_axis_tready;
    outLast_d      = outLast_q;
    count_d        = count_q;
    pendGlbl_d     = pendGlbl_q;
    pendAdc_d      = pendAdc_q;
    hdrGlbl_d      = hdrGlbl_q;
    hdrAdc_d       = hdrAdc_q;
    trlGlbl_d      = trlGlbl_q;
    trlAdc_d       = trlAdc_q;
    payloadBeats_d = payloadBeats_q;
    lenErr_d       = lenErr_q;
    shortErr_d     = shortErr_q;
    oversizeErr_d  = oversizeErr_q;
    reportValid_d  = 1'b0;
    frameCount_d   = frameCount_q;
    doReport       = 1'b0;
    repHdrGlbl     = pendGlbl_q;
    repHdrAdc      = pendAdc_q;
    repBeats       = count_q;
    repShort       = 1'b0;
    repOver        = 1'b0;
    expBeats       = '0;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (s_axis_tlast) begin
            doReport   = 1'b1;
            repHdrGlbl = beatUpper;
            repHdrAdc  = beatLower;
            repBeats   = '0;
            repShort   = 1'b1;
          end else begin
            pendGlbl_d = beatUpper;
            pendAdc_d  = beatLower;
            count_d    = '0;
            state_d    = S_FIRST;
          end
        end
      end
      S_FIRST: begin
        if (accept) begin
          if (s_axis_tlast) begin
            doReport = 1'b1;
            repBeats = '0;
            state_d  = S_HDR;
          end else begin
            holdData_d = s_axis_tdata;
            count_d    = 32'd1;
            state_d    = S_PAY;
          end
        end
      end
      S_PAY: begin
        // Hold is full here; any accepted beat pushes it into the out stage.
        if (accept) begin
          outValid_d = 1'b1;
          outData_d  = holdData_q;
          if (s_axis_tlast) begin
            outLast_d = 1'b1;
            doReport  = 1'b1;
            state_d   = S_HDR;
          end else if (count_q < 32'(MAX_PAYLOAD)) begin
            outLast_d  = 1'b0;
            holdData_d = s_axis_tdata;
            count_d    = count_q + 32'd1;
          end else begin
            outLast_d = 1'b1;
            state_d   = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (accept && s_axis_tlast) begin
          doReport = 1'b1;
          repOver  = 1'b1;
          state_d  = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase

    if (doReport) begin
      expBeats       = beatLower - repHdrAdc - 32'(CNT_ADJ);
      hdrGlbl_d      = repHdrGlbl;
      hdrAdc_d       = repHdrAdc;
      trlGlbl_d      = beatUpper;
      trlAdc_d       = beatLower;
      payloadBeats_d = repBeats;
      shortErr_d     = repShort;
      oversizeErr_d  = repOver;
      lenErr_d       = !repShort && !repOver && (repBeats != expBeats);
      reportValid_d  = 1'b1;
      frameCount_d   = frameCount_q + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= S_HDR;
      holdData_q     <= '0;
      outData_q      <= '0;
      outValid_q     <= 1'b0;
      outLast_q      <= 1'b0;
      count_q        <= '0;
      pendGlbl_q     <= '0;
      pendAdc_q      <= '0;
      hdrGlbl_q      <= '0;
      hdrAdc_q       <= '0;
      trlGlbl_q      <= '0;
      trlAdc_q       <= '0;
      payloadBeats_q <= '0;
      lenErr_q       <= 1'b0;
      shortErr_q     <= 1'b0;
      oversizeErr_q  <= 1'b0;
      reportValid_q  <= 1'b0;
      frameCount_q   <= '0;
    end else begin
      state_q        <= state_d;
      holdData_q     <= holdData_d;
      outData_q      <= outData_d;
      outValid_q     <= outValid_d;
      outLast_q      <= outLast_d;
      count_q        <= count_d;
      pendGlbl_q     <= pendGlbl_d;
      pendAdc_q      <= pendAdc_d;
      hdrGlbl_q      <= hdrGlbl_d;
      hdrAdc_q       <= hdrAdc_d;
      trlGlbl_q      <= trlGlbl_d;
      trlAdc_q       <= trlAdc_d;
      payloadBeats_q <= payloadBeats_d;
      lenErr_q       <= lenErr_d;
      shortErr_q     <= shortErr_d;
      oversizeErr_q  <= oversizeErr_d;
      reportValid_q  <= reportValid_d;
      frameCount_q   <= frameCount_d;
    end
  end

  assign m_axis_tdata  = outData_q;
  assign m_axis_tvalid = outValid_q;
  assign m_axis_tlast  = outLast_q;
  assign report_valid  = reportValid_q;
  assign hdr_glbl      = hdrGlbl_q;
  assign hdr_adc       = hdrAdc_q;
  assign trl_glbl      = trlGlbl_q;
  assign trl_adc       = trlAdc_q;
  assign payload_beats = payloadBeats_q;
  assign len_err       = lenErr_q;
  assign short_err     = shortErr_q;
  assign oversize_err  = oversizeErr_q;
  assign frame_count   = frameCount_q;

endmodule

// File: tb/tb_adc_frame_deframer.sv
// Randomized frame-level bench for adc_frame_deframer: frames are described as
// header/payload/trailer and expected output beats and reports are derived per frame.
module tb_adc_frame_deframer;

  localparam int MAX = 4;
  localparam int ADJ = 1;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        report_valid;
  logic [31:0] hdr_glbl, hdr_adc, trl_glbl, trl_adc, payload_beats, frame_count;
  logic        len_err, short_err, oversize_err;

  adc_frame_deframer #(.DATA_WIDTH(64), .MAX_PAYLOAD(MAX), .CNT_ADJ(ADJ)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .report_valid(report_valid), .hdr_glbl(hdr_glbl), .hdr_adc(hdr_adc),
    .trl_glbl(trl_glbl), .trl_adc(trl_adc), .payload_beats(payload_beats),
    .len_err(len_err), .short_err(short_err), .oversize_err(oversize_err),
    .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] hg, ha, tg, ta, pb, fc;
    logic        len, sht, ovr;
  } report_t;

  logic [64:0] expBeats[$];
  report_t     expReports[$];
  logic [31:0] modelFrames = '0;
  int          checkCount = 0;
  int          passCount = 0;
  int          readyMode = 0;
  bit          ignoreOut = 1'b1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Downstream ready: always on, the 1,0,0,1 pattern, or random.
  initial begin
    automatic bit [3:0] pat = 4'b1001;
    automatic int phase = 0;
    forever begin
      @(negedge aclk);
      case (readyMode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = pat[phase % 4];
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      phase++;
    end
  end

  // Monitor samples just before each rising edge, when every input has settled.
  initial begin
    automatic bit          prevStall = 1'b0;
    automatic logic [63:0] prevData = '0;
    automatic logic        prevLast = 1'b0;
    automatic logic [31:0] lastPb = '0;
    logic [64:0] e;
    report_t r;
    forever begin
      @(negedge aclk);
      #4;
      if (ignoreOut || !aresetn) begin
        prevStall = 1'b0;
        lastPb = '0;
        continue;
      end
      if (prevStall) begin
        checkOutput("stall_data", m_axis_tdata, prevData);
        checkOutput("stall_last", 64'(m_axis_tlast), 64'(prevLast));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expBeats.size() == 0) checkOutput("unexpected_beat", 64'(1), 64'(0));
        else begin
          e = expBeats.pop_front();
          checkOutput("beat_data", m_axis_tdata, e[63:0]);
          checkOutput("beat_last", 64'(m_axis_tlast), 64'(e[64]));
        end
      end
      prevStall = m_axis_tvalid && !m_axis_tready;
      prevData = m_axis_tdata;
      prevLast = m_axis_tlast;
      if (!s_axis_tready)
        checkOutput("stall_cause", 64'({m_axis_tvalid, m_axis_tready}), 64'(2'b10));
      if (report_valid) begin
        if (expReports.size() == 0) checkOutput("unexpected_report", 64'(1), 64'(0));
        else begin
          r = expReports.pop_front();
          checkOutput("hdr_glbl", 64'(hdr_glbl), 64'(r.hg));
          checkOutput("hdr_adc", 64'(hdr_adc), 64'(r.ha));
          checkOutput("trl_glbl", 64'(trl_glbl), 64'(r.tg));
          checkOutput("trl_adc", 64'(trl_adc), 64'(r.ta));
          checkOutput("payload_beats", 64'(payload_beats), 64'(r.pb));
          checkOutput("len_err", 64'(len_err), 64'(r.len));
          checkOutput("short_err", 64'(short_err), 64'(r.sht));
          checkOutput("oversize_err", 64'(oversize_err), 64'(r.ovr));
          checkOutput("frame_count", 64'(frame_count), 64'(r.fc));
        end
        lastPb = payload_beats;
      end else begin
        checkOutput("report_hold", 64'(payload_beats), 64'(lastPb));
      end
    end
  end

  // Entered and left at a falling edge; holds the beat until it is accepted.
  task automatic applyStimulus(input logic [63:0] data, input logic last);
    int  waitCycles;
    bit  done;
    int  gap;
    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    repeat (gap) @(negedge aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    done = 1'b0;
    waitCycles = 0;
    while (!done && waitCycles < 1000) begin
      #4;
      if (s_axis_tready) done = 1'b1;
      @(negedge aclk);
      waitCycles++;
    end
    if (!done) checkOutput("accept_timeout", 64'(0), 64'(1));
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic sendFrame(input logic [31:0] g, input logic [31:0] a, input int n,
                           input logic [31:0] tg, input logic [31:0] ta);
    logic [63:0] pay[$];
    report_t     r;
    int          fwd;
    fwd = (n > MAX) ? MAX : n;
    for (int i = 0; i < n; i++) pay.push_back({$urandom, $urandom});
    for (int i = 0; i < fwd; i++) expBeats.push_back({(i == fwd - 1), pay[i]});
    modelFrames = modelFrames + 32'd1;
    r.hg = g; r.ha = a; r.tg = tg; r.ta = ta;
    r.pb = 32'(fwd);
    r.sht = 1'b0;
    r.ovr = (n > MAX);
    r.len = !r.ovr && (32'(fwd) != (ta - a - 32'(ADJ)));
    r.fc = modelFrames;
    expReports.push_back(r);
    applyStimulus({g, a}, 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(pay[i], 1'b0);
    applyStimulus({tg, ta}, 1'b1);
  endtask

  task automatic sendShort(input logic [31:0] g, input logic [31:0] a);
    report_t r;
    modelFrames = modelFrames + 32'd1;
    r.hg = g; r.ha = a; r.tg = g; r.ta = a;
    r.pb = '0; r.sht = 1'b1; r.ovr = 1'b0; r.len = 1'b0; r.fc = modelFrames;
    expReports.push_back(r);
    applyStimulus({g, a}, 1'b1);
  endtask

  task automatic waitDrain();
    int cycles = 0;
    readyMode = 0;
    while ((expBeats.size() != 0 || expReports.size() != 0) && cycles < 2000) begin
      @(negedge aclk);
      cycles++;
    end
    repeat (4) @(negedge aclk);
    checkOutput("drain_beats", 64'(expBeats.size()), 64'(0));
    checkOutput("drain_reports", 64'(expReports.size()), 64'(0));
  endtask

  initial begin
    logic [31:0] a, g;
    int n, fwd;
    $display("[TB] start");
    repeat (3) @(negedge aclk);
    checkOutput("rst_s_tready", 64'(s_axis_tready), 64'(1));
    checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    checkOutput("rst_report", 64'(report_valid), 64'(0));
    checkOutput("rst_frame_count", 64'(frame_count), 64'(0));
    checkOutput("rst_payload", 64'(payload_beats), 64'(0));
    aresetn = 1'b1;
    ignoreOut = 1'b0;
    @(negedge aclk);

    readyMode = 0;
    sendFrame(32'h100, 32'h10, 4, 32'h108, 32'h15);
    readyMode = 1;
    sendFrame(32'h100, 32'h10, 4, 32'h108, 32'h15);
    readyMode = 0;
    sendFrame(32'h200, 32'h10, 4, 32'h208, 32'h18);
    sendShort(32'h300, 32'h30);
    sendFrame(32'h400, 32'h40, 0, 32'h401, 32'h41);
    sendFrame(32'h500, 32'h50, 7, 32'h509, 32'h59);
    sendFrame(32'h600, 32'hFFFF_FFFE, 2, 32'h604, 32'h0000_0001);
    waitDrain();

    ignoreOut = 1'b1;
    applyStimulus({32'h700, 32'h70}, 1'b0);
    applyStimulus(64'hAAAA_0000_0000_0001, 1'b0);
    applyStimulus(64'hAAAA_0000_0000_0002, 1'b0);
    aresetn = 1'b0;
    #1;
    checkOutput("midrst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    checkOutput("midrst_report", 64'(report_valid), 64'(0));
    checkOutput("midrst_frame_count", 64'(frame_count), 64'(0));
    checkOutput("midrst_trl_adc", 64'(trl_adc), 64'(0));
    checkOutput("midrst_s_tready", 64'(s_axis_tready), 64'(1));
    expBeats.delete();
    expReports.delete();
    modelFrames = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    ignoreOut = 1'b0;
    sendFrame(32'h800, 32'h80, 3, 32'h805, 32'h84);

    for (int f = 0; f < 40; f++) begin
      readyMode = int'($urandom_range(0, 2));
      g = $urandom;
      a = $urandom;
      if ($urandom_range(0, 5) == 0) sendShort(g, a);
      else begin
        n = int'($urandom_range(0, 7));
        fwd = (n > MAX) ? MAX : n;
        if ($urandom_range(0, 1) == 0) sendFrame(g, a, n, g + 32'd9, a + 32'(fwd) + 32'(ADJ));
        else sendFrame(g, a, n, $urandom, $urandom);
      end
    end
    waitDrain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
